dmem_wb_arbiter: RTL and testbench

- Two-master to one-slave Wishbone pipelined arbiter in front of the data memory.
- Master 0 is the load/store unit; master 1 is the debug/boot loader (or a DMA engine).
- Grant is held for a whole bus cycle (CYC high). Outstanding requests are counted so every ACK is returned to the master that issued it.
- Slave-side signals connect directly to the data memory Wishbone port.

---
 rtl/dmem_wb_arbiter.sv | 157 +++++++++++++++
 tb/tb_dmem_wb_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_wb_arbiter.sv
// Two-master to one-slave Wishbone pipelined arbiter in front of data memory.
// Define DMEM_ARB_FIXED_PRIO_EN for fixed master-0 priority (default: round-robin).
module dmem_wb_arbiter #(
    parameter int AW              = 13,
    parameter int DW              = 32,
    parameter int SW              = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_m0_cyc,
    input  logic          i_m0_stb,
    input  logic          i_m0_we,
    input  logic [AW-1:0] i_m0_addr,
    input  logic [DW-1:0] i_m0_data,
    input  logic [SW-1:0] i_m0_sel,
    output logic [DW-1:0] o_m0_data,
    output logic          o_m0_ack,
    output logic          o_m0_stall,
    input  logic          i_m1_cyc,
    input  logic          i_m1_stb,
    input  logic          i_m1_we,
    input  logic [AW-1:0] i_m1_addr,
    input  logic [DW-1:0] i_m1_data,
    input  logic [SW-1:0] i_m1_sel,
    output logic [DW-1:0] o_m1_data,
    output logic          o_m1_ack,
    output logic          o_m1_stall,
    output logic          o_s_cyc,
    output logic          o_s_stb,
    output logic          o_s_we,
    output logic [AW-1:0] o_s_addr,
    output logic [DW-1:0] o_s_data,
    output logic [SW-1:0] o_s_sel,
    input  logic [DW-1:0] i_s_data,
    input  logic          i_s_ack,
    input  logic          i_s_stall
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic [CW-1:0] count_q, count_d, count_nxt;
    logic          full, accept, ack_cnt, tie_pick;

    assign full    = (count_q == CW'(MAX_OUTSTANDING));
    assign accept  = o_s_stb & ~i_s_stall;
    assign ack_cnt = i_s_ack & (count_q != '0);

`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign tie_pick = 1'b0;
`else
    assign tie_pick = ~last_q;
`endif

    // An ACK on an empty counter is a stray response and never underflows
    always_comb begin
        count_nxt = count_q;
        if (accept && !ack_cnt) begin
            count_nxt = count_q + CW'(1);
        end else if (!accept && ack_cnt) begin
            count_nxt = count_q - CW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        count_d = count_q;
        unique case (state_q)
            IDLE: begin
                count_d = '0;
                if (i_m0_cyc && (!i_m1_cyc || !tie_pick)) begin
                    state_d = G0;
                    last_d  = 1'b0;
                end else if (i_m1_cyc) begin
                    state_d = G1;
                    last_d  = 1'b1;
                end
            end
            G0: begin
                if (!i_m0_cyc) begin
                    state_d = IDLE;
                    count_d = '0;
                end else begin
                    count_d = count_nxt;
                end
            end
            G1: begin
                if (!i_m1_cyc) begin
                    state_d = IDLE;
                    count_d = '0;
                end else begin
                    count_d = count_nxt;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        o_s_cyc    = 1'b0;
        o_s_stb    = 1'b0;
        o_s_we     = 1'b0;
        o_s_addr   = '0;
        o_s_data   = '0;
        o_s_sel    = '0;
        o_m0_stall = 1'b1;
        o_m1_stall = 1'b1;
        if (state_q == G0) begin
            o_s_cyc    = i_m0_cyc;
            o_s_stb    = i_m0_stb & ~full;
            o_s_we     = i_m0_we;
            o_s_addr   = i_m0_addr;
            o_s_data   = i_m0_data;
            o_s_sel    = i_m0_sel;
            o_m0_stall = i_s_stall | full;
        end else if (state_q == G1) begin
            o_s_cyc    = i_m1_cyc;
            o_s_stb    = i_m1_stb & ~full;
            o_s_we     = i_m1_we;
            o_s_addr   = i_m1_addr;
            o_s_data   = i_m1_data;
            o_s_sel    = i_m1_sel;
            o_m1_stall = i_s_stall | full;
        end
    end

    // Read data is broadcast; only the owning master sees the ACK
    assign o_m0_ack  = i_s_ack & (state_q == G0);
    assign o_m1_ack  = i_s_ack & (state_q == G1);
    assign o_m0_data = i_s_data;
    assign o_m1_data = i_s_data;

endmodule

// File: tb/tb_dmem_wb_arbiter.sv
// Scoreboard bench for dmem_wb_arbiter with a delayed-ACK data memory model.
// Honours DMEM_ARB_FIXED_PRIO_EN for the tie-break expectation.
module tb_dmem_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m_cyc [2];
    logic        m_stb [2];
    logic        m_we  [2];
    logic [12:0] m_addr[2];
    logic [31:0] m_wd  [2];
    logic [3:0]  m_sel [2];
    logic [31:0] o_m0_data, o_m1_data;
    logic        o_m0_ack, o_m1_ack, o_m0_stall, o_m1_stall;
    logic        s_cyc, s_stb, s_we;
    logic [12:0] s_addr;
    logic [31:0] s_wdata, s_rdata;
    logic [3:0]  s_sel;
    logic        s_ack;
    logic        s_stall = 1'b0;

    dmem_wb_arbiter dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_m0_cyc(m_cyc[0]), .i_m0_stb(m_stb[0]), .i_m0_we(m_we[0]),
        .i_m0_addr(m_addr[0]), .i_m0_data(m_wd[0]), .i_m0_sel(m_sel[0]),
        .o_m0_data(o_m0_data), .o_m0_ack(o_m0_ack), .o_m0_stall(o_m0_stall),
        .i_m1_cyc(m_cyc[1]), .i_m1_stb(m_stb[1]), .i_m1_we(m_we[1]),
        .i_m1_addr(m_addr[1]), .i_m1_data(m_wd[1]), .i_m1_sel(m_sel[1]),
        .o_m1_data(o_m1_data), .o_m1_ack(o_m1_ack), .o_m1_stall(o_m1_stall),
        .o_s_cyc(s_cyc), .o_s_stb(s_stb), .o_s_we(s_we),
        .o_s_addr(s_addr), .o_s_data(s_wdata), .o_s_sel(s_sel),
        .i_s_data(s_rdata), .i_s_ack(s_ack), .i_s_stall(s_stall)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Data memory model: words >= 64 preloaded, ACK after dly cycles
    typedef struct packed {
        logic        v;
        logic [31:0] d;
    } rsp_t;
    rsp_t        sr[16];
    logic [31:0] mem[2048];
    int          dly = 1;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) sr[i] <= '0;
            for (int i = 0; i < 2048; i++)
                mem[i] <= (i >= 64) ? 32'hA5A5_0000 + 32'(i) : 32'h0;
        end else begin
            for (int i = 0; i < 15; i++) sr[i] <= sr[i+1];
            sr[15] <= '0;
            if (s_cyc && s_stb && !s_stall) begin
                sr[dly-1] <= {1'b1, mem[s_addr[12:2]]};
                if (s_we)
                    for (int b = 0; b < 4; b++)
                        if (s_sel[b]) mem[s_addr[12:2]][8*b +: 8] <= s_wdata[8*b +: 8];
            end
        end
    end
    assign s_ack   = sr[0].v;
    assign s_rdata = sr[0].d;

    typedef struct {
        int          m;
        logic [31:0] d;
        bit          chk;
    } exp_t;
    exp_t sbq[$];
    int   rcv[2] = '{0, 0};
    int   first_ack = -1;
    int   last_ack = -1;
    int   both_gnt = 0;
    bit   tr_en = 0;
    int   tr_code = 0;
    int   tr_last = -1;

    // Monitor: every ACK pops one expectation
    always @(negedge clk) begin
        int          am;
        int          g;
        logic [31:0] ad;
        exp_t        e;
        if (rst_n) begin
            if (o_m0_ack && o_m1_ack) begin
                checks++;
                failures++;
                $display("FAIL both_ack actual=11 required=one-hot");
            end else if (o_m0_ack || o_m1_ack) begin
                am = o_m1_ack ? 1 : 0;
                ad = o_m1_ack ? o_m1_data : o_m0_data;
                rcv[am]++;
                if (first_ack < 0) first_ack = cyc_n;
                last_ack = cyc_n;
                checks++;
                if (sbq.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_ack actual=m%0d/%h required=none", am, ad);
                end else begin
                    e = sbq.pop_front();
                    if (e.m != am || (e.chk && e.d !== ad)) begin
                        failures++;
                        $display("FAIL ack_route actual=m%0d/%h required=m%0d/%h",
                                 am, ad, e.m, e.d);
                    end
                end
            end
            if (!o_m0_stall && !o_m1_stall) both_gnt++;
            g = !o_m0_stall ? 0 : (!o_m1_stall ? 1 : 2);
            if (tr_en && g != tr_last) begin
                tr_code = tr_code * 10 + g;
                tr_last = g;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic logic stall_of(input int m);
        return (m == 1) ? o_m1_stall : o_m0_stall;
    endfunction

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic run(input int m, input int n, input logic we,
                       input logic [12:0] a0, input logic [31:0] wd,
                       input logic [3:0] sel, input logic [31:0] e0,
                       input bit push, input bit hold,
                       output int kfs, output int stalls);
        int   k = 0;
        int   t = 0;
        int   target;
        exp_t e;
        kfs    = -1;
        stalls = 0;
        target = rcv[m] + (push ? n : 0);
        tick();
        m_cyc[m]  = 1'b1;
        m_stb[m]  = 1'b1;
        m_we[m]   = we;
        m_addr[m] = a0;
        m_wd[m]   = wd;
        m_sel[m]  = sel;
        while (k < n && t < 200) begin
            if (!stall_of(m)) begin
                if (push) begin
                    e.m   = m;
                    e.d   = e0 + 32'(k);
                    e.chk = !we;
                    sbq.push_back(e);
                end
                k++;
            end else if (k > 0) begin
                stalls++;
                if (kfs < 0) kfs = k;
            end
            tick();
            t++;
            if (k < n) begin
                m_addr[m] = a0 + 13'(4 * k);
                m_wd[m]   = wd + 32'(k);
            end else begin
                m_stb[m] = 1'b0;
            end
        end
        if (t >= 200) begin
            checks++;
            failures++;
            $display("FAIL stb_timeout actual=%0d required=%0d", k, n);
        end
        t = 0;
        while (hold && rcv[m] != target && t < 200) begin
            tick();
            t++;
        end
        if (t >= 200) begin
            checks++;
            failures++;
            $display("FAIL ack_timeout actual=%0d required=%0d", rcv[m], target);
        end
        m_cyc[m] = 1'b0;
        m_stb[m] = 1'b0;
        m_we[m]  = 1'b0;
    endtask

    task automatic gap();
        repeat (3) tick();
    endtask

    initial begin
        int kfs0, st0, kfs1, st1, r0, r1, rr_exp;
        for (int i = 0; i < 2; i++) begin
            m_cyc[i] = 1'b1;
            m_stb[i] = 1'b0;
            m_we[i] = 1'b0;
            m_addr[i] = '0;
            m_wd[i] = '0;
            m_sel[i] = 4'hF;
        end
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_m0_ack", 32'(o_m0_ack), 32'd0);
        chk("rst_m1_ack", 32'(o_m1_ack), 32'd0);
        chk("rst_m0_stall", 32'(o_m0_stall), 32'd1);
        chk("rst_m1_stall", 32'(o_m1_stall), 32'd1);
        chk("rst_s_cyc", 32'(s_cyc), 32'd0);
        chk("rst_s_addr", 32'(s_addr), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_tie_m0_stall", 32'(o_m0_stall), 32'd0);
        chk("first_tie_m1_stall", 32'(o_m1_stall), 32'd1);
        chk("first_tie_s_cyc", 32'(s_cyc), 32'd1);
        #2;
        m_cyc[0] = 1'b0;
        m_cyc[1] = 1'b0;
        gap();

        r0 = rcv[0];
        run(0, 1, 1'b1, 13'h010, 32'hDEAD_BEEF, 4'b0011, 32'h0, 1, 1, kfs0, st0);
        chk("write_ack_count", 32'(rcv[0] - r0), 32'd1);
        gap();
        run(0, 1, 1'b0, 13'h010, 32'h0, 4'hF, 32'h0000_BEEF, 1, 1, kfs0, st0);
        chk("read_ack_count", 32'(rcv[0] - r0), 32'd2);
        gap();
        run(1, 1, 1'b0, 13'h200, 32'h0, 4'hF, 32'hA5A5_0080, 1, 1, kfs1, st1);
        gap();

        r0 = rcv[0];
        r1 = rcv[1];
        tr_code = 0;
        tr_last = -1;
        tr_en = 1;
        fork
            run(0, 3, 1'b0, 13'h100, 32'h0, 4'hF, 32'hA5A5_0040, 1, 1, kfs0, st0);
            run(1, 3, 1'b0, 13'h200, 32'h0, 4'hF, 32'hA5A5_0080, 1, 1, kfs1, st1);
        join
        tr_en = 0;
        chk("tie1_grant_trace", 32'(tr_code), 32'd2021);
        chk("tie1_acks", 32'(rcv[0] - r0 + rcv[1] - r1), 32'd6);
        gap();

        first_ack = -1;
        r0 = rcv[0];
        run(0, 8, 1'b0, 13'h300, 32'h0, 4'hF, 32'hA5A5_00C0, 1, 1, kfs0, st0);
        chk("burst_stalls", 32'(st0), 32'd0);
        chk("burst_ack_span", 32'(last_ack - first_ack), 32'd7);
        chk("burst_acks", 32'(rcv[0] - r0), 32'd8);
        gap();

`ifdef DMEM_ARB_FIXED_PRIO_EN
        rr_exp = 2021;
`else
        rr_exp = 2120;
`endif
        tr_code = 0;
        tr_last = -1;
        tr_en = 1;
        fork
            run(0, 3, 1'b0, 13'h100, 32'h0, 4'hF, 32'hA5A5_0040, 1, 1, kfs0, st0);
            run(1, 3, 1'b0, 13'h200, 32'h0, 4'hF, 32'hA5A5_0080, 1, 1, kfs1, st1);
        join
        tr_en = 0;
        chk("tie2_grant_trace", 32'(tr_code), 32'(rr_exp));
        gap();

        dly = 6;
        run(0, 6, 1'b0, 13'h400, 32'h0, 4'hF, 32'hA5A5_0100, 1, 1, kfs0, st0);
        chk("limit_accepts", 32'(kfs0), 32'd4);
        chk("limit_stall_cycles", 32'(st0), 32'd3);
        gap();

        r0 = rcv[0];
        r1 = rcv[1];
        run(0, 2, 1'b0, 13'h100, 32'h0, 4'hF, 32'h0, 0, 0, kfs0, st0);
        tick();
        chk("abort_idle_stall", 32'(o_m0_stall), 32'd1);
        chk("abort_idle_s_cyc", 32'(s_cyc), 32'd0);
        repeat (10) tick();
        chk("abort_no_late_ack", 32'(rcv[0] - r0 + rcv[1] - r1), 32'd0);
        run(0, 6, 1'b0, 13'h500, 32'h0, 4'hF, 32'hA5A5_0140, 1, 1, kfs0, st0);
        chk("abort_count_cleared", 32'(kfs0), 32'd4);
        gap();

        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        chk("never_both_granted", 32'(both_gnt), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
